// File: rtl/cond_exec_unit.sv
// Execute-stage conditional-execution unit: NZCV flag groups, condition check,
// enable qualification and an IT-style predicated-block sequencer.
module cond_exec_unit #(
  parameter int  GROUPS   = 2,
  parameter int  IT_DEPTH = 4,
  localparam int LW       = $clog2(IT_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_e,
  input  logic                stall,
  input  logic                flush,
  input  logic [3:0]          Cond,
  input  logic [3:0]          ALUFlags,
  input  logic [GROUPS-1:0]   FlagW,
  input  logic                PCS,
  input  logic                RegW,
  input  logic                MemW,
  input  logic                it_start,
  input  logic [3:0]          it_cond,
  input  logic [LW-1:0]       it_len,
  input  logic [IT_DEPTH-1:0] it_mask,
  output logic                PCSrc,
  output logic                RegWrite,
  output logic                MemWrite,
  output logic [GROUPS-1:0]   FlagWrite,
  output logic                CondEx,
  output logic [3:0]          Flags,
  output logic                it_active,
  output logic [LW-1:0]       it_remaining,
  output logic                it_err
);

  localparam logic [LW-1:0] DEPTH_L = LW'(IT_DEPTH);

  logic [3:0]          flags_q, flags_d;
  logic [LW-1:0]       it_rem_q, it_rem_d;
  logic [IT_DEPTH-1:0] mask_q, mask_d;
  logic [3:0]          itc_q, itc_d;
  logic                err_q, err_d;
  logic                acc, blk_start, nested, en;
  logic [3:0]          ec;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = ~cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cf & ~z;
      4'b1001: cond_pass = ~(cf & ~z);
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = ~(~z & (n == v));
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_comb begin
    acc       = valid_e & ~stall & ~flush;
    it_active = (it_rem_q != '0);
    // Else slots flip bit 0 of the base condition, so AL becomes never.
    ec        = it_active ? {itc_q[3:1], itc_q[0] ^ ~mask_q[0]} : Cond;
    CondEx    = cond_pass(ec, flags_q);
    blk_start = acc & it_start & ~it_active;
    nested    = acc & it_start & it_active;
    en        = CondEx & acc & ~it_start;
    PCSrc     = PCS & en;
    RegWrite  = RegW & en;
    MemWrite  = MemW & en;
    FlagWrite = FlagW & {GROUPS{en}};
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      flags_d[b] = FlagWrite[b * GROUPS / 4] ? ALUFlags[b] : flags_q[b];
    end
    it_rem_d = it_rem_q;
    mask_d   = mask_q;
    itc_d    = itc_q;
    err_d    = err_q;
    if (flush) begin
      it_rem_d = '0;
      mask_d   = '0;
    end else if (blk_start) begin
      it_rem_d = (it_len > DEPTH_L) ? DEPTH_L : it_len;
      mask_d   = it_mask;
      itc_d    = it_cond;
      if (it_len > DEPTH_L) err_d = 1'b1;
    end else if (acc && it_active) begin
      // A slot is consumed whether or not it passed; a taken branch ends the block.
      it_rem_d = PCSrc ? '0 : it_rem_q - LW'(1);
      mask_d   = mask_q >> 1;
      if (nested) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= '0;
      it_rem_q <= '0;
      mask_q   <= '0;
      itc_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      it_rem_q <= it_rem_d;
      mask_q   <= mask_d;
      itc_q    <= itc_d;
      err_q    <= err_d;
    end
  end

  assign Flags        = flags_q;
  assign it_remaining = it_rem_q;
  assign it_err       = err_q;

endmodule

// File: doc/cond_exec_unit.md
# cond_exec_unit

Parametrised conditional-execution unit for the pipelined ARM-like core, sitting in the Execute stage between the decoder's control outputs and the write-enable consumers: register file, data memory and PC mux. It holds the architectural NZCV flags in independently writable groups and evaluates the 4-bit condition field against them. It qualifies instruction side effects with valid, stall and flush. It also runs a predicated-block sequencer: an IT-style instruction sets condition and then/else polarity for up to IT_DEPTH following instructions.

## Interface
- GROUPS, 2, number of independently writable flag groups; legal values 1, 2, 4; group g covers Flags[(g+1)*4/GROUPS-1 : g*4/GROUPS].
- IT_DEPTH, 4, maximum predicated-block length; legal values 1..8; LW = $clog2(IT_DEPTH+1).
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid_e  in  1  an instruction is present in Execute.
- stall  in  1  Execute is held; no side effects and no state update this cycle.
- flush  in  1  Execute instruction is squashed; clears predicated-block state.
- Cond  in  4  instruction condition field (0000 EQ … 1110 AL, 1111 never).
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  GROUPS  per-group flag-write request.
- PCS, RegW, MemW  in  1 each  unqualified branch, register-write and memory-write requests.
- it_start  in  1  current instruction opens a predicated block.
- it_cond  in  4  block base condition.
- it_len  in  LW  number of predicated instructions that follow.
- it_mask  in  IT_DEPTH  per-slot polarity, bit 0 first; 1 = then (it_cond), 0 = else (it_cond with bit 0 inverted).
- PCSrc, RegWrite, MemWrite  out  1 each  qualified enables.
- FlagWrite  out  GROUPS  qualified flag-group write enables.
- CondEx  out  1  effective condition passed.
- Flags  out  4  registered {N,Z,C,V}.
- it_active  out  1  a predicated block is in progress.
- it_remaining  out  LW  slots left in the block.
- it_err  out  1  sticky protocol-error flag.

## Operation
- Accepted instruction: acc = valid_e & ~stall & ~flush.
- Effective condition:
  - When it_active, ec = {it_cond[3:1], it_cond[0] ^ ~mask_q[0]}.
  - Otherwise, ec = Cond.
  - An else slot on AL (1110) yields 1111, which is never.
- CondEx decode against the registered Flags:
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~(C&~Z).
  - GE N==V, LT N!=V, GT ~Z&(N==V), LE its inverse.
  - AL 1, 1111 0.
- Enable qualification:
  - PCSrc = PCS & CondEx & acc. RegWrite and MemWrite follow the same form.
  - FlagWrite[g] = FlagW[g] & CondEx & acc.
- Flags update: on each edge, each group with FlagWrite[g]=1 loads the matching ALUFlags slice. Other groups hold.
- Block start: when acc & it_start & ~it_active:
  - the instruction itself is unconditional and causes no side effects; all enables are 0;
  - it_remaining loads min(it_len, IT_DEPTH) and mask_q loads it_mask;
  - it_len = 0 opens no block;
  - it_len > IT_DEPTH clamps and sets it_err.
- Slot consumption: each acc cycle while it_active consumes one slot. it_remaining decrements and mask_q shifts right by 1, whether CondEx passed or not.
- Block end:
  - it_active = (it_remaining != 0);
  - a taken branch inside a block (PCSrc=1) forces it_remaining to 0;
  - flush forces it_remaining to 0 regardless of valid_e.
- Nested it_start while it_active: treated as a normal slot with its enables forced 0. It sets it_err and does not reload the block.
- it_err clears only on reset.

## Timing
- Reset values:
  - Flags = 0000, it_remaining = 0, mask_q = 0, it_err = 0.
  - it_active = 0.
  - With Flags = 0, CondEx for EQ is 0 and for AL is 1.
- CondEx and all enables are combinational in the same cycle as the inputs.
- Flag write latency is one cycle: a flag write in cycle n is seen by the condition check in cycle n+1. There is no same-cycle forwarding.
- it_active rises the cycle after an accepted it_start.
- The stall cycle is a full hold: flags, counter and mask are unchanged, and the instruction is re-evaluated when stall drops.
- Simultaneous flush and stall: flush wins; the block is cleared.
- Asynchronous reset mid-block: the block is abandoned immediately and the outputs take their reset values at once.

## Test plan
- Reset, then an ADDS with ALUFlags=0100 and FlagW=11, Cond=1110 → FlagWrite=11. The next cycle Flags=0100, and Cond=0000 with RegW=1 gives RegWrite=1.
- Flags=1000 (N set, V clear): Cond=1010 GE → CondEx=0; Cond=1011 LT → CondEx=1. With FlagW=01 and ALUFlags=0011, the next cycle Flags=1011.
- it_start, it_cond=0000, it_len=3, it_mask=101, Z=1 → the three following RegW instructions produce RegWrite 1,0,1. it_remaining goes 3,2,1,0.
- Stall for 2 cycles on slot 2 of the previous block → RegWrite=0 and it_remaining holds at 2. After release, slot 2 evaluates as else.
- Block of 4 with a taken branch in slot 2 → PCSrc=1 and it_remaining becomes 0 the next cycle. Flush in slot 1 of a new block → it_active=0 the next cycle.
- Nested it_start inside a block, and separately it_len=7 with IT_DEPTH=4 → it_err=1 and stays set. The clamped block runs exactly 4 slots.
